// File: rtl/delay_timer_arb_pkg.sv
// Shared widths and helpers for the delay timer arbiter slice.
package delay_timer_arb_pkg;

  localparam int unsigned CNT_W   = 3;
  localparam logic [2:0]  CNT_MAX = 3'd7;

  // Counter start value so that an up-count to CNT_MAX takes len increments.
  function automatic logic [2:0] load_value(input logic [2:0] len);
    return CNT_MAX - len;
  endfunction

endpackage

// File: rtl/delay_counter_3bit.sv
// Loadable 3-bit up-counter with async active-low clear; load wins over enable.
module delay_counter_3bit
  import delay_timer_arb_pkg::*;
(
  input  logic             clk,
  input  logic             clr_al_in,
  input  logic             load_in,
  input  logic [CNT_W-1:0] load_val_in,
  input  logic             en_in,
  output logic [CNT_W-1:0] count_out
);

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  // Next count: load, increment or hold.
  always_comb begin
    count_d = count_q;
    if (load_in) begin
      count_d = load_val_in;
    end else if (en_in) begin
      count_d = count_q + 3'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Counter register, cleared asynchronously.
  always_ff @(posedge clk or negedge clr_al_in) begin
    if (!clr_al_in) begin
      count_q <= 3'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out = count_q;

endmodule

// File: rtl/delay_timer_arb.sv
// Two-requester round-robin arbiter that runs a per-grant programmable delay
// and pulses done to the winner when the delay expires.
module delay_timer_arb
  import delay_timer_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_al_in,
  input  logic [1:0] req_in,
  input  logic [2:0] len0_in,
  input  logic [2:0] len1_in,
  output logic [1:0] gnt_out,
  output logic [1:0] done_out,
  output logic       busy_out,
  output logic [2:0] count_out
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state_d, state_q;
  logic [1:0]       gnt_d, gnt_q;
  logic             last_d, last_q;     // index of requester granted most recently
  logic             win_s;
  logic             cnt_load_s;
  logic             cnt_en_s;
  logic [CNT_W-1:0] cnt_load_val_s;
  logic [CNT_W-1:0] count_s;

  delay_counter_3bit u_counter (
    .clk         (clk),
    .clr_al_in   (reset_al_in),
    .load_in     (cnt_load_s),
    .load_val_in (cnt_load_val_s),
    .en_in       (cnt_en_s),
    .count_out   (count_s)
  );

  // State, grant and round-robin pointer registers; pointer resets to requester 1.
  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      state_q <= ST_IDLE;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  // Arbitration, next-state and counter control.
  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    last_d         = last_q;
    win_s          = 1'b0;
    cnt_load_s     = 1'b0;
    cnt_en_s       = 1'b0;
    cnt_load_val_s = 3'd0;
    case (state_q)
      ST_IDLE: begin
        if (req_in != 2'b00) begin
          // Contention goes to whoever was not served last.
          if (req_in == 2'b11) begin
            win_s = ~last_q;
          end else begin
            win_s = req_in[1];
          end
          state_d        = ST_COUNT;
          last_d         = win_s;
          gnt_d          = win_s ? 2'b10 : 2'b01;
          cnt_load_s     = 1'b1;
          cnt_load_val_s = load_value(win_s ? len1_in : len0_in);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COUNT: begin
        if ((req_in & gnt_q) != 2'b00) begin
          // Never increment from the maximum; expiry moves to DONE instead.
          if (count_s == CNT_MAX) begin
            state_d = ST_DONE;
          end else begin
            cnt_en_s = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
          gnt_d   = 2'b00;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    gnt_out   = gnt_q;
    busy_out  = (state_q != ST_IDLE);
    count_out = count_s;
    if (state_q == ST_DONE) begin
      done_out = gnt_q;
    end else begin
      done_out = 2'b00;
    end
  end

endmodule

// File: tb/tb_delay_timer_arb.sv
// Scoreboard bench for delay_timer_arb: a transaction-level model predicts
// per-cycle outputs and the cycle of every done pulse; a monitor compares.
module tb_delay_timer_arb;

  logic       clk = 1'b0;
  logic       reset_al_in;
  logic [1:0] req_in;
  logic [2:0] len0_in, len1_in;
  logic [1:0] gnt_out, done_out;
  logic       busy_out;
  logic [2:0] count_out;

  always #5 clk = ~clk;

  delay_timer_arb dut (
    .clk         (clk),
    .reset_al_in (reset_al_in),
    .req_in      (req_in),
    .len0_in     (len0_in),
    .len1_in     (len1_in),
    .gnt_out     (gnt_out),
    .done_out    (done_out),
    .busy_out    (busy_out),
    .count_out   (count_out)
  );

  typedef struct packed {
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;
    logic [2:0] cnt;
  } exp_t;

  typedef struct {
    int cyc;
    int who;
  } done_ev_t;

  exp_t     exp_q[$];
  done_ev_t done_q[$];
  exp_t     mon_e;
  done_ev_t mon_d;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Reference model: phase 0 idle, 1 counting, 2 done.
  int m_phase = 0;
  int m_owner = 0;
  int m_count = 0;
  int m_last  = 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_count = 0;
    m_last  = 1;
    exp_q.delete();
    done_q.delete();
  endtask

  // One clock edge of the behavioural model with the inputs held over it.
  task automatic model_edge(logic [1:0] r, int l0, int l1);
    int w;
    int len;
    exp_t e;
    if (m_phase == 0) begin
      if (r != 2'b00) begin
        if (r == 2'b11) w = 1 - m_last;
        else if (r == 2'b10) w = 1;
        else w = 0;
        len     = (w == 1) ? l1 : l0;
        m_last  = w;
        m_owner = w;
        m_count = 7 - len;
        m_phase = 1;
        done_q.push_back('{cyc + len + 1, w});
      end
    end else if (m_phase == 1) begin
      if (!r[m_owner]) begin
        m_phase = 0;
        void'(done_q.pop_back());
      end else if (m_count == 7) begin
        m_phase = 2;
      end else begin
        m_count = m_count + 1;
      end
    end else begin
      m_phase = 0;
    end
    e.busy = (m_phase != 0);
    e.gnt  = (m_phase != 0) ? (2'b01 << m_owner) : 2'b00;
    e.done = (m_phase == 2) ? (2'b01 << m_owner) : 2'b00;
    e.cnt  = m_count[2:0];
    exp_q.push_back(e);
  endtask

  task automatic step(logic [1:0] r, logic [2:0] a, logic [2:0] b);
    req_in  = r;
    len0_in = a;
    len1_in = b;
    @(posedge clk);
    #1;
    cyc++;
    model_edge(r, int'(a), int'(b));
  endtask

  task automatic run(logic [1:0] r, logic [2:0] a, logic [2:0] b, int n);
    for (int i = 0; i < n; i++) step(r, a, b);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_gnt"},   gnt_out,   0);
    check({tag, "_done"},  done_out,  0);
    check({tag, "_busy"},  busy_out,  0);
    check({tag, "_count"}, count_out, 0);
  endtask

  // Monitor: per-cycle output compare plus done-pulse timing against the model.
  always @(negedge clk) begin
    if (reset_al_in === 1'b1) begin
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("gnt",   gnt_out,   mon_e.gnt);
        check("done",  done_out,  mon_e.done);
        check("busy",  busy_out,  mon_e.busy);
        check("count", count_out, mon_e.cnt);
      end
      if (done_q.size() > 0 && done_q[0].cyc < cyc) begin
        mon_d = done_q.pop_front();
        check("done_missing_at", cyc, mon_d.cyc);
      end
      if (done_out != 2'b00) begin
        if (done_q.size() > 0 && done_q[0].cyc == cyc) begin
          mon_d = done_q.pop_front();
          check("done_who", done_out, 2'b01 << mon_d.who);
        end else begin
          check("done_unexpected", done_out, 0);
        end
      end
    end
  end

  initial begin
    logic [1:0] r;
    req_in      = 2'b00;
    len0_in     = 3'd0;
    len1_in     = 3'd0;
    reset_al_in = 1'b1;
    #1 reset_al_in = 1'b0;
    #2 check_reset_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1 reset_al_in = 1'b1;
    model_reset();

    // Idle with no requests: counter holds, nothing happens.
    run(2'b00, 3'd5, 3'd5, 2);

    // Requester 0, L=3: counts 4..7, done four edges after the first count.
    run(2'b01, 3'd3, 3'd0, 5);
    run(2'b00, 3'd0, 3'd0, 2);

    // Both held: alternating grants with one-cycle done pulses.
    run(2'b11, 3'd2, 3'd5, 30);
    run(2'b00, 3'd0, 3'd0, 2);

    // Requester 1 with L=0: straight to 7, done on the next edge.
    run(2'b10, 3'd0, 3'd0, 2);
    run(2'b00, 3'd0, 3'd0, 3);

    // Abort after two counts, then contention goes to requester 1.
    run(2'b01, 3'd6, 3'd0, 3);
    step(2'b00, 3'd6, 3'd0);
    run(2'b11, 3'd6, 3'd6, 10);
    run(2'b00, 3'd0, 3'd0, 3);

    // Asynchronous reset between edges while counting.
    run(2'b01, 3'd5, 3'd0, 3);
    #1 reset_al_in = 1'b0;
    #1 check_reset_outputs("midreset");
    model_reset();
    #1 reset_al_in = 1'b1;
    run(2'b00, 3'd0, 3'd0, 3);

    // Length change after grant must not alter the running delay.
    step(2'b01, 3'd4, 3'd0);
    run(2'b01, 3'd1, 3'd0, 5);
    run(2'b00, 3'd0, 3'd0, 3);

    // Random traffic with persistent requests and changing lengths.
    r = 2'b00;
    for (int i = 0; i < 500; i++) begin
      r = r ^ {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
      step(r, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    // Drain and confirm every predicted done pulse was seen.
    run(2'b00, 3'd0, 3'd0, 12);
    @(negedge clk);
    #1 check("done_drain", done_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
